// File: rtl/ef_pkg.sv
// Shared definitions for the E/F step decoder: step-state codes, decoder
// states, step classes and the fault-counter saturation limit.
package ef_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } dec_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

endpackage

// File: rtl/ef_step_decoder_if.sv
// Decoder bus: step-state input, clear, and recovered outputs.
// The pos signal exists only when EF_DEC_POS_EN is defined.
interface ef_step_decoder_if;
  logic [1:0] present_in;
  logic       clr;
  logic       e_out;
  logic       f_out;
  logic       err;
  logic [3:0] err_cnt;
`ifdef EF_DEC_POS_EN
  logic [7:0] pos;
`endif

  modport master (
    output present_in, clr,
`ifdef EF_DEC_POS_EN
    input  pos,
`endif
    input  e_out, f_out, err, err_cnt
  );

  modport slave (
    input  present_in, clr,
`ifdef EF_DEC_POS_EN
    output pos,
`endif
    output e_out, f_out, err, err_cnt
  );
endinterface

// File: rtl/ef_step_classify.sv
// Combinational step classifier: compares two consecutive 2-bit step states
// and reports hold / up / down / illegal (two-state jump).
module ef_step_classify
  import ef_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] present_in,
  output step_t      cls
);
  logic [1:0] delta;

  assign delta = present_in - prev;

  always_comb begin
    cls = STEP_HOLD;
    unique case (delta)
      2'd0: cls = STEP_HOLD;
      2'd1: cls = STEP_UP;
      2'd3: cls = STEP_DOWN;
      2'd2: cls = STEP_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/ef_step_decoder.sv
// E/F step decoder: recovers enable/direction from a 2-bit step-state stream,
// flags illegal jumps, and (with EF_DEC_POS_EN) keeps a wrapping position.
module ef_step_decoder
  import ef_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ef_step_decoder_if.slave   bus
);
  dec_state_t state, state_nxt;
  logic [1:0] prev;
  step_t      cls;
  logic       e_q, e_nxt;
  logic       f_q, f_nxt;
  logic       err_q, err_nxt;
  logic [3:0] cnt_q, cnt_nxt;

  ef_step_classify u_classify (
    .prev       (prev),
    .present_in (bus.present_in),
    .cls        (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
      prev  <= S0;
      e_q   <= 1'b0;
      f_q   <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      prev  <= bus.present_in;
      e_q   <= e_nxt;
      f_q   <= f_nxt;
      err_q <= err_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    e_nxt     = 1'b0;
    f_nxt     = f_q;
    err_nxt   = err_q;
    cnt_nxt   = cnt_q;

    unique case (state)
      SYNC: state_nxt = TRACK;
      TRACK: begin
        unique case (cls)
          STEP_HOLD: ;
          STEP_UP: begin
            e_nxt = 1'b1;
            f_nxt = 1'b1;
          end
          STEP_DOWN: begin
            e_nxt = 1'b1;
            f_nxt = 1'b0;
          end
          STEP_ILLEGAL: begin
            err_nxt   = 1'b1;
            state_nxt = FAULT;
          end
        endcase
      end
      FAULT: err_nxt = 1'b1;
      default: state_nxt = SYNC;
    endcase

    // The fault counter ignores clr, so it counts even when clr wins the edge.
    if ((state == TRACK || state == FAULT) && cls == STEP_ILLEGAL && cnt_q != ERR_CNT_MAX)
      cnt_nxt = cnt_q + 4'd1;

    if (bus.clr) begin
      state_nxt = SYNC;
      err_nxt   = 1'b0;
      e_nxt     = 1'b0;
      f_nxt     = f_q;
    end
  end

  assign bus.e_out   = e_q;
  assign bus.f_out   = f_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;

`ifdef EF_DEC_POS_EN
  logic [7:0] pos_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pos_q <= '0;
    else if (bus.clr)
      pos_q <= '0;
    else if (state == TRACK && cls == STEP_UP)
      pos_q <= pos_q + 8'd1;
    else if (state == TRACK && cls == STEP_DOWN)
      pos_q <= pos_q - 8'd1;
  end

  assign bus.pos = pos_q;
`endif
endmodule

// File: tb/tb_ef_step_decoder.sv
// Directed bench for ef_step_decoder with an arithmetic reference model;
// pos checks are active when EF_DEC_POS_EN is defined.
module tb_ef_step_decoder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ef_step_decoder_if bus ();

  ef_step_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for first sample, 1 = tracking, 2 = faulted.
  int         m_mode;
  logic [1:0] m_prev;
  int         m_e, m_f, m_err, m_cnt, m_pos;

  function automatic int delta(input logic [1:0] a, input logic [1:0] b);
    return (int'(b) - int'(a) + 4) % 4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_prev <= 2'b00; m_e <= 0; m_f <= 0;
      m_err  <= 0; m_cnt  <= 0;     m_pos <= 0;
    end else begin
      m_prev <= bus.present_in;
      m_e    <= 0;
      if (m_mode != 0 && delta(m_prev, bus.present_in) == 2)
        m_cnt <= (m_cnt < 15) ? m_cnt + 1 : 15;
      if (bus.clr) begin
        m_mode <= 0; m_err <= 0; m_pos <= 0;
      end else if (m_mode == 0) begin
        m_mode <= 1;
      end else if (m_mode == 1) begin
        case (delta(m_prev, bus.present_in))
          1: begin m_e <= 1; m_f <= 1; m_pos <= (m_pos + 1) % 256; end
          3: begin m_e <= 1; m_f <= 0; m_pos <= (m_pos + 255) % 256; end
          2: begin m_err <= 1; m_mode <= 2; end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_e_out",   int'(bus.e_out),   m_e);
    chk("model_f_out",   int'(bus.f_out),   m_f);
    chk("model_err",     int'(bus.err),     m_err);
    chk("model_err_cnt", int'(bus.err_cnt), m_cnt);
`ifdef EF_DEC_POS_EN
    chk("model_pos",     int'(bus.pos),     m_pos);
`endif
  end

  task automatic step(input logic [1:0] p, input logic c);
    @(negedge clk);
    bus.present_in = p;
    bus.clr        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pos_is(input string name, input int exp);
`ifdef EF_DEC_POS_EN
    chk(name, int'(bus.pos), exp);
`else
    if (exp < 0) $display("unreachable %s", name);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.present_in = 2'b00;
    bus.clr        = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_e",   int'(bus.e_out),   0);
    chk("reset_err", int'(bus.err),     0);
    chk("reset_cnt", int'(bus.err_cnt), 0);
    reset = 1'b0;

    // Up run 00,01,10,11,00: sync, then four up steps.
    step(2'b00, 1'b0);
    chk("up_sync_e", int'(bus.e_out), 0);
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    chk("up_e", int'(bus.e_out), 1);
    chk("up_f", int'(bus.f_out), 1);
    pos_is("up_pos", 4);

    // Up step then hold at 10 for five edges.
    step(2'b01, 1'b0);
    step(2'b10, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b10, 1'b0);
    chk("hold_e", int'(bus.e_out), 0);
    chk("hold_f", int'(bus.f_out), 1);
    pos_is("hold_pos", 6);

    // Clear to pos 0, resync at 00, then down steps wrap.
    step(2'b10, 1'b1);
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    chk("down_e", int'(bus.e_out), 1);
    chk("down_f", int'(bus.f_out), 0);
    pos_is("down_pos1", 255);
    step(2'b10, 1'b0);
    pos_is("down_pos2", 254);

    // Illegal jump 00 -> 10.
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    chk("ill_err", int'(bus.err),     1);
    chk("ill_cnt", int'(bus.err_cnt), 1);
    chk("ill_e",   int'(bus.e_out),   0);
    step(2'b11, 1'b0);
    chk("fault_e",   int'(bus.e_out), 0);
    chk("fault_err", int'(bus.err),   1);
    pos_is("fault_pos", 252);
    step(2'b11, 1'b1);
    chk("clr_err", int'(bus.err),     0);
    chk("clr_cnt", int'(bus.err_cnt), 1);
    pos_is("clr_pos", 0);
    step(2'b00, 1'b0);
    chk("clr_sync_e", int'(bus.e_out), 0);

    // Sixteen illegal jumps saturate the counter.
    for (int i = 0; i < 16; i++) step((i % 2 == 0) ? 2'b10 : 2'b00, 1'b0);
    chk("sat_cnt", int'(bus.err_cnt), 15);
    chk("sat_err", int'(bus.err),     1);

    // clr wins over an illegal jump on the same edge.
    step(2'b00, 1'b1);
    step(2'b00, 1'b0);
    step(2'b10, 1'b1);
    chk("prio_err", int'(bus.err), 0);
    step(2'b11, 1'b0);
    chk("prio_sync_e", int'(bus.e_out), 0);
    chk("prio_cnt", int'(bus.err_cnt), 15);

    // Async reset mid-run.
    step(2'b00, 1'b0);
    step(2'b01, 1'b0);
    chk("pre_rst_e", int'(bus.e_out), 1);
    #2;
    reset = 1'b1;
    bus.present_in = 2'b10;
    #1;
    chk("arst_e",   int'(bus.e_out),   0);
    chk("arst_f",   int'(bus.f_out),   0);
    chk("arst_cnt", int'(bus.err_cnt), 0);
    pos_is("arst_pos", 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_e",   int'(bus.e_out), 0);
    chk("post_rst_err", int'(bus.err),   0);
    step(2'b11, 1'b0);
    chk("post_rst_up_e", int'(bus.e_out), 1);
    chk("post_rst_up_f", int'(bus.f_out), 1);
    pos_is("post_rst_pos", 1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
